tlc_lights_decoder: RTL and testbench
=====================================

Name: tlc_lights_decoder

Overview:
- Reader for the 9-bit `lights` bus that the light combiner drives.
- Samples `lights` every clock and recovers the active direction and phase, measuring how long each phase lasts.
- Checks the light sequence for illegal patterns and reports them as registered status and sticky error flags.
- Sits beside the combiner in the TLC top level. Feeds the status display and the bench checker.

Parameters:
- MIN_YELLOW, 2: minimum number of consecutive yellow cycles required before red.
- CNT_W, 8: width of the dwell counter; the counter saturates at its maximum value.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- lights  input  9  light bus: [8:6]=NS, [5:3]=EW, [2:0]=LT; each triple is {green,yellow,red}
- clr_err  input  1  synchronous clear of all sticky error flags
- active_dir  output  2  direction currently green or yellow: 0=NS, 1=EW, 2=LT
- active_valid  output  1  1 when some direction is green or yellow
- phase  output  2  phase of active_dir: 0=all-red, 1=green, 2=yellow
- dwell  output  CNT_W  cycles spent in the current phase; the first cycle of a phase reads 0
- dir_change  output  1  one-cycle pulse when a new direction turns green
- err_illegal  output  1  sticky: a triple was not exactly one-hot
- err_conflict  output  1  sticky: more than one direction was non-red
- err_seq  output  1  sticky: illegal transition on one direction
- err_yellow_short  output  1  sticky: yellow lasted fewer than MIN_YELLOW cycles

Behaviour:
- Every output is a register and is updated on the rising edge of clk. Latency is 1 cycle: a `lights` value sampled at edge N appears on the outputs after edge N.
- Reset (rst=1) sets every output to 0. It also clears the internal previous-lights register to all-red (9'b001001001).
- Reset has priority over clr_err and over any error detection in the same cycle.
- Per-triple decode:
  - Legal triple values are 100 (green), 010 (yellow) and 001 (red).
  - Any other value sets err_illegal. For that cycle the triple is treated as red.
- Conflict check: if two or more triples are green or yellow in the same cycle:
  - Set err_conflict.
  - Hold active_dir, active_valid and phase at their previous values.
  - Keep counting dwell.
- Active decode, when there is no conflict:
  - Exactly one non-red triple: active_valid=1, active_dir=its index, phase=1 for green or 2 for yellow.
  - All triples red: active_valid=0, phase=0, active_dir holds the last value.
- Per-direction transitions, checked against the previous sample:
  - Legal: red->red, red->green, green->green, green->yellow, yellow->yellow, yellow->red.
  - Illegal: green->red, yellow->green, red->yellow. Any of these sets err_seq.
- Yellow length check:
  - An internal counter counts consecutive yellow cycles for the active direction.
  - On a yellow->red transition, if the count is less than MIN_YELLOW, set err_yellow_short.
- dwell:
  - Resets to 0 on any change of the {active_valid, active_dir, phase} tuple.
  - Otherwise increments by 1 each cycle and saturates at 2^CNT_W-1, with no wrap-around.
- dir_change:
  - Pulses 1 for exactly one cycle when phase becomes 1 for an active_dir different from the last direction that was green.
  - Does not pulse on the first green after reset; the "last green" value resets to 'none'.
- Sticky errors:
  - Once set, an error flag holds until rst or clr_err.
  - If clr_err and a new error occur in the same cycle, the new error wins and the flag reads 1.
- Value 3 on active_dir is never produced.

Test Plan:
- Reset, then hold lights=001001001 for 5 cycles:
  - Expect all outputs 0.
  - Expect dwell counting 0,1,2,3 with phase=0.
- Drive EW green for 4 cycles, yellow for 2, then red (lights=001100001, 001010001, 001001001):
  - active_dir=1, phase 1->2->0, dwell resets at each phase change.
  - No errors.
  - No dir_change, because this is the first green after reset.
- Continue with LT green (001001100):
  - dir_change pulses once, one cycle after the sample.
  - active_dir=2.
- Drive EW yellow for 1 cycle then red:
  - err_yellow_short=1 and stays 1.
  - clr_err pulse -> the flag returns to 0.
- Drive NS and EW green together (100100001):
  - err_conflict=1.
  - active_dir, active_valid and phase hold their previous values.
- Drive EW green->red directly: err_seq=1.
  - Drive triple 110 on NS: err_illegal=1.
  - Assert rst during yellow: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/tlc_lights_decoder.sv
// Decoder for the 9-bit traffic-light bus. It recovers the active direction, phase and
// dwell time, and flags illegal light patterns with sticky error bits.
module tlc_lights_decoder #(
    parameter int MIN_YELLOW = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       lights,
    input  logic             clr_err,
    output logic [1:0]       active_dir,
    output logic             active_valid,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] dwell,
    output logic             dir_change,
    output logic             err_illegal,
    output logic             err_conflict,
    output logic             err_seq,
    output logic             err_yellow_short
);

    localparam logic [1:0]       ST_RED    = 2'd0;
    localparam logic [1:0]       ST_GREEN  = 2'd1;
    localparam logic [1:0]       ST_YELLOW = 2'd2;
    localparam logic [8:0]       ALL_RED   = 9'b001001001;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] MIN_Y     = CNT_W'(MIN_YELLOW);

    // Non-one-hot triples decode as red so that they never become the active direction.
    function automatic logic [1:0] decode_triple(input logic [2:0] t);
        case (t)
            3'b100:  decode_triple = ST_GREEN;
            3'b010:  decode_triple = ST_YELLOW;
            default: decode_triple = ST_RED;
        endcase
    endfunction

    logic [8:0]       prev_lights_reg;
    logic [CNT_W-1:0] yel_cnt_reg, yel_cnt_next;
    logic             last_green_valid_reg, last_green_valid_next;
    logic [1:0]       last_green_dir_reg, last_green_dir_next;

    logic [2:0][1:0]  cur_st;
    logic [2:0][1:0]  prev_st;
    logic [2:0]       illegal;
    logic [2:0]       non_red;
    logic [2:0]       seq_bad;
    logic [2:0]       yel_to_red;

    // Triple index 0 = NS [8:6], 1 = EW [5:3], 2 = LT [2:0].
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_triple
            logic [2:0] cur_t;
            logic [2:0] prev_t;
            assign cur_t       = lights[8-3*gi -: 3];
            assign prev_t      = prev_lights_reg[8-3*gi -: 3];
            assign cur_st[gi]  = decode_triple(cur_t);
            assign prev_st[gi] = decode_triple(prev_t);
            assign illegal[gi] = !((cur_t == 3'b100) || (cur_t == 3'b010) || (cur_t == 3'b001));
            assign non_red[gi] = (cur_st[gi] != ST_RED);
            assign seq_bad[gi] = ((prev_st[gi] == ST_GREEN)  && (cur_st[gi] == ST_RED))    ||
                                 ((prev_st[gi] == ST_YELLOW) && (cur_st[gi] == ST_GREEN))  ||
                                 ((prev_st[gi] == ST_RED)    && (cur_st[gi] == ST_YELLOW));
            assign yel_to_red[gi] = (prev_st[gi] == ST_YELLOW) && (cur_st[gi] == ST_RED);
        end
    endgenerate

    logic conflict;
    assign conflict = (non_red[0] & non_red[1]) | (non_red[0] & non_red[2]) | (non_red[1] & non_red[2]);

    logic             valid_next;
    logic [1:0]       dir_next;
    logic [1:0]       phase_next;
    logic [CNT_W-1:0] dwell_next;
    logic             dir_change_next;
    logic             prev_yel_active;
    logic             tuple_changed;
    logic             entering_green;

    // On a conflict the previous active tuple is held.
    always_comb begin
        valid_next = active_valid;
        dir_next   = active_dir;
        phase_next = phase;
        if (!conflict) begin
            if (non_red == 3'b000) begin
                valid_next = 1'b0;
                phase_next = ST_RED;
            end else begin
                valid_next = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    if (non_red[i]) begin
                        dir_next   = 2'(i);
                        phase_next = cur_st[i];
                    end
                end
            end
        end
    end

    always_comb begin
        tuple_changed = {valid_next, dir_next, phase_next} != {active_valid, active_dir, phase};
        if (tuple_changed) begin
            dwell_next = '0;
        end else if (dwell == CNT_MAX) begin
            dwell_next = dwell;
        end else begin
            dwell_next = dwell + 1'b1;
        end
    end

    // Consecutive yellow count for the active direction; restarts at 1 on entering yellow.
    always_comb begin
        prev_yel_active = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ((dir_next == 2'(i)) && (prev_st[i] == ST_YELLOW)) begin
                prev_yel_active = 1'b1;
            end
        end
        if (!conflict && valid_next && (phase_next == ST_YELLOW)) begin
            if (!prev_yel_active) begin
                yel_cnt_next = CNT_W'(1);
            end else if (yel_cnt_reg == CNT_MAX) begin
                yel_cnt_next = yel_cnt_reg;
            end else begin
                yel_cnt_next = yel_cnt_reg + 1'b1;
            end
        end else begin
            yel_cnt_next = '0;
        end
    end

    always_comb begin
        entering_green = valid_next && (phase_next == ST_GREEN) &&
                         (!active_valid || (phase != ST_GREEN) || (dir_next != active_dir));
        dir_change_next = entering_green && last_green_valid_reg && (last_green_dir_reg != dir_next);
        last_green_valid_next = last_green_valid_reg;
        last_green_dir_next   = last_green_dir_reg;
        if (valid_next && (phase_next == ST_GREEN)) begin
            last_green_valid_next = 1'b1;
            last_green_dir_next   = dir_next;
        end
    end

    logic err_illegal_next, err_conflict_next, err_seq_next, err_yellow_short_next;

    // A new error in the same cycle as clr_err still sets the flag.
    always_comb begin
        err_illegal_next      = (|illegal) | (err_illegal & ~clr_err);
        err_conflict_next     = conflict | (err_conflict & ~clr_err);
        err_seq_next          = (|seq_bad) | (err_seq & ~clr_err);
        err_yellow_short_next = ((|yel_to_red) && (yel_cnt_reg < MIN_Y)) |
                                (err_yellow_short & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_lights_reg      <= ALL_RED;
            yel_cnt_reg          <= '0;
            last_green_valid_reg <= 1'b0;
            last_green_dir_reg   <= 2'd0;
            active_dir           <= 2'd0;
            active_valid         <= 1'b0;
            phase                <= ST_RED;
            dwell                <= '0;
            dir_change           <= 1'b0;
            err_illegal          <= 1'b0;
            err_conflict         <= 1'b0;
            err_seq              <= 1'b0;
            err_yellow_short     <= 1'b0;
        end else begin
            prev_lights_reg      <= lights;
            yel_cnt_reg          <= yel_cnt_next;
            last_green_valid_reg <= last_green_valid_next;
            last_green_dir_reg   <= last_green_dir_next;
            active_dir           <= dir_next;
            active_valid         <= valid_next;
            phase                <= phase_next;
            dwell                <= dwell_next;
            dir_change           <= dir_change_next;
            err_illegal          <= err_illegal_next;
            err_conflict         <= err_conflict_next;
            err_seq              <= err_seq_next;
            err_yellow_short     <= err_yellow_short_next;
        end
    end

endmodule

// File: tb/tb_tlc_lights_decoder.sv
// Directed bench for tlc_lights_decoder: drives light sequences one clock at a time
// and checks every output against hand-computed values.
module tb_tlc_lights_decoder;

    localparam logic [8:0] ALL_RED  = 9'b001001001;
    localparam logic [8:0] EW_GRN   = 9'b001100001;
    localparam logic [8:0] EW_YEL   = 9'b001010001;
    localparam logic [8:0] LT_GRN   = 9'b001001100;
    localparam logic [8:0] LT_YEL   = 9'b001001010;
    localparam logic [8:0] NSEW_GRN = 9'b100100001;
    localparam logic [8:0] NS_BAD   = 9'b110001001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] lights = ALL_RED;
    logic       clr_err = 1'b0;
    logic [1:0] active_dir;
    logic       active_valid;
    logic [1:0] phase;
    logic [7:0] dwell;
    logic       dir_change;
    logic       err_illegal, err_conflict, err_seq, err_yellow_short;

    int n_vec = 0;
    int n_err = 0;

    tlc_lights_decoder #(.MIN_YELLOW(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .lights(lights), .clr_err(clr_err),
        .active_dir(active_dir), .active_valid(active_valid), .phase(phase),
        .dwell(dwell), .dir_change(dir_change), .err_illegal(err_illegal),
        .err_conflict(err_conflict), .err_seq(err_seq), .err_yellow_short(err_yellow_short)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one input vector, clock it in, then sample 1 ns after the edge.
    task automatic step(input logic [8:0] l, input logic c, input logic r);
        lights  = l;
        clr_err = c;
        rst     = r;
        @(posedge clk);
        #1;
        $display("t=%0t lights=%09b clr=%0b rst=%0b -> dir=%0d v=%0b ph=%0d dw=%0d dc=%0b err(i,c,s,y)=%0b%0b%0b%0b",
                 $time, l, c, r, active_dir, active_valid, phase, dwell, dir_change,
                 err_illegal, err_conflict, err_seq, err_yellow_short);
    endtask

    task automatic chk_act(input string tag, input logic [1:0] d, input logic v,
                           input logic [1:0] p, input logic [7:0] dw);
        chk({tag, ".dir"}, 32'(active_dir), 32'(d));
        chk({tag, ".valid"}, 32'(active_valid), 32'(v));
        chk({tag, ".phase"}, 32'(phase), 32'(p));
        chk({tag, ".dwell"}, 32'(dwell), 32'(dw));
    endtask

    task automatic chk_err(input string tag, input logic [3:0] e);
        chk({tag, ".errs"}, 32'({err_illegal, err_conflict, err_seq, err_yellow_short}), 32'(e));
    endtask

    initial begin
        // Reset with all red
        step(ALL_RED, 1'b0, 1'b1);
        step(ALL_RED, 1'b0, 1'b1);
        chk_act("rst", 2'd0, 1'b0, 2'd0, 8'd0);
        chk("rst.dc", 32'(dir_change), 32'd0);
        chk_err("rst", 4'b0000);
        for (int i = 1; i <= 4; i++) begin
            step(ALL_RED, 1'b0, 1'b0);
            chk_act("allred", 2'd0, 1'b0, 2'd0, 8'(i));
        end

        // EW green 4, yellow 2, red: no errors, no dir_change (first green)
        for (int i = 0; i < 4; i++) begin
            step(EW_GRN, 1'b0, 1'b0);
            chk_act("ew_grn", 2'd1, 1'b1, 2'd1, 8'(i));
            chk("ew_grn.dc", 32'(dir_change), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            step(EW_YEL, 1'b0, 1'b0);
            chk_act("ew_yel", 2'd1, 1'b1, 2'd2, 8'(i));
        end
        step(ALL_RED, 1'b0, 1'b0);
        chk_act("ew_red", 2'd1, 1'b0, 2'd0, 8'd0);
        chk_err("ew_cycle", 4'b0000);

        // LT green: dir_change pulses for one cycle
        step(LT_GRN, 1'b0, 1'b0);
        chk_act("lt_grn", 2'd2, 1'b1, 2'd1, 8'd0);
        chk("lt_grn.dc1", 32'(dir_change), 32'd1);
        step(LT_GRN, 1'b0, 1'b0);
        chk("lt_grn.dc2", 32'(dir_change), 32'd0);
        step(LT_YEL, 1'b0, 1'b0);
        step(LT_YEL, 1'b0, 1'b0);
        step(ALL_RED, 1'b0, 1'b0);
        chk_err("lt_cycle", 4'b0000);

        // EW green, yellow for one cycle only, then red: short yellow
        step(EW_GRN, 1'b0, 1'b0);
        chk("ew2.dc", 32'(dir_change), 32'd1);
        step(EW_GRN, 1'b0, 1'b0);
        step(EW_YEL, 1'b0, 1'b0);
        chk_err("ew2_yel", 4'b0000);
        step(ALL_RED, 1'b0, 1'b0);
        chk_err("yshort", 4'b0001);
        step(ALL_RED, 1'b0, 1'b0);
        chk_err("yshort_sticky", 4'b0001);
        step(ALL_RED, 1'b1, 1'b0);
        chk_err("yshort_clr", 4'b0000);

        // EW green (last green was EW, so no pulse), then NS+EW conflict
        step(EW_GRN, 1'b0, 1'b0);
        chk("ew3.dc", 32'(dir_change), 32'd0);
        chk_act("ew3", 2'd1, 1'b1, 2'd1, 8'd0);
        step(NSEW_GRN, 1'b0, 1'b0);
        chk_act("conflict", 2'd1, 1'b1, 2'd1, 8'd1);
        chk_err("conflict", 4'b0100);
        step(NSEW_GRN, 1'b1, 1'b0);
        chk_act("conflict_clr", 2'd1, 1'b1, 2'd1, 8'd2);
        chk_err("conflict_clr_wins", 4'b0100);

        // Reset mid-conflict: everything back to zero
        step(NSEW_GRN, 1'b1, 1'b1);
        chk_act("rst2", 2'd0, 1'b0, 2'd0, 8'd0);
        chk_err("rst2", 4'b0000);

        // EW green -> red directly: sequence error
        step(ALL_RED, 1'b0, 1'b0);
        step(EW_GRN, 1'b0, 1'b0);
        chk("ew4.dc", 32'(dir_change), 32'd0);
        step(ALL_RED, 1'b0, 1'b0);
        chk_err("g2r", 4'b0010);

        // Illegal triple 110 on NS, treated as red
        step(NS_BAD, 1'b0, 1'b0);
        chk_act("illegal", 2'd1, 1'b0, 2'd0, 8'd1);
        chk_err("illegal", 4'b1010);
        step(ALL_RED, 1'b1, 1'b0);
        chk_err("clr_all", 4'b0000);

        // Reset during yellow, then yellow again: previous lights reset to all-red
        step(EW_GRN, 1'b0, 1'b0);
        step(EW_GRN, 1'b0, 1'b0);
        step(EW_YEL, 1'b0, 1'b0);
        chk_act("pre_rst_yel", 2'd1, 1'b1, 2'd2, 8'd0);
        step(EW_YEL, 1'b0, 1'b1);
        chk_act("rst_yel", 2'd0, 1'b0, 2'd0, 8'd0);
        chk("rst_yel.dc", 32'(dir_change), 32'd0);
        chk_err("rst_yel", 4'b0000);
        step(EW_YEL, 1'b0, 1'b0);
        chk_act("post_rst_yel", 2'd1, 1'b1, 2'd2, 8'd0);
        chk_err("r2y", 4'b0010);

        // Dwell saturation at 255
        step(ALL_RED, 1'b0, 1'b1);
        for (int i = 1; i <= 260; i++) begin
            lights = ALL_RED; clr_err = 1'b0; rst = 1'b0;
            @(posedge clk);
            #1;
            if (i == 254) chk("dwell_254", 32'(dwell), 32'd254);
        end
        chk("dwell_sat", 32'(dwell), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
